// File: rtl/udp_jpeg_pkt_scheduler_if.sv
// rtl/udp_jpeg_pkt_scheduler_if.sv - frame-buffer and UDP-sender handshake bundle for the packet scheduler
interface udp_jpeg_pkt_scheduler_if;
    logic        i_frame_start;
    logic [23:0] i_frame_len;
    logic        i_abort;
    logic        o_frame_ready;
    logic        o_frame_done;
    logic        o_frame_aborted;
    logic        o_send_en;
    logic [15:0] o_pkt_len;
    logic        o_pkt_last;
    logic [14:0] o_pkt_rank;
    logic [15:0] o_ipv4_sign;
    logic [23:0] o_pkt_offset;
    logic        i_send_busy;

    modport master (
        input  i_frame_start, i_frame_len, i_abort, i_send_busy,
        output o_frame_ready, o_frame_done, o_frame_aborted, o_send_en,
        output o_pkt_len, o_pkt_last, o_pkt_rank, o_ipv4_sign, o_pkt_offset
    );

    modport slave (
        output i_frame_start, i_frame_len, i_abort, i_send_busy,
        input  o_frame_ready, o_frame_done, o_frame_aborted, o_send_en,
        input  o_pkt_len, o_pkt_last, o_pkt_rank, o_ipv4_sign, o_pkt_offset
    );
endinterface

// File: rtl/udp_jpeg_pkt_scheduler.sv
// rtl/udp_jpeg_pkt_scheduler.sv - splits one buffered MJPEG frame into UDP payload packets
module udp_jpeg_pkt_scheduler #(
    parameter int          MAX_PAYLOAD    = 1024,
    parameter int          GAP_CYCLES     = 16,
    parameter logic [15:0] IPV4_SIGN_INIT = 16'h0
) (
    input  logic                     i_udp_clk50m,
    input  logic                     i_rst,
    udp_jpeg_pkt_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_DONE
    } state_t;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [23:0]      MAX_LEN  = 24'(MAX_PAYLOAD);

    state_t           state;
    state_t           state_nxt;
    logic [23:0]      remaining;
    logic [23:0]      pkt_offset;
    logic [15:0]      pkt_len;
    logic [15:0]      ipv4_sign;
    logic             pkt_last;
    logic [14:0]      pkt_rank;
    logic             abort_q;
    logic             zero_done;
    logic [GAP_W-1:0] gap_cnt;
    logic             start_hit;
    logic             frame_empty;
    logic             fits;

    assign start_hit   = (state == S_IDLE) && bus.i_frame_start;
    assign frame_empty = (bus.i_frame_len == 24'd0);
    assign fits        = (remaining <= MAX_LEN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start_hit && !frame_empty) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (bus.i_send_busy) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!bus.i_send_busy) begin
                    if (pkt_last || abort_q) state_nxt = S_DONE;
                    else                     state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (abort_q)                  state_nxt = S_DONE;
                else if (gap_cnt == GAP_LAST) state_nxt = S_LOAD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_udp_clk50m or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_udp_clk50m or posedge i_rst) begin
        if (i_rst) begin
            remaining  <= 24'd0;
            pkt_offset <= 24'd0;
            pkt_len    <= 16'd0;
            pkt_last   <= 1'b0;
            pkt_rank   <= 15'd0;
            ipv4_sign  <= IPV4_SIGN_INIT;
            abort_q    <= 1'b0;
            zero_done  <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            // An empty frame completes straight from IDLE without touching the packet registers.
            zero_done <= start_hit && frame_empty;

            if (state == S_DONE)                       abort_q <= 1'b0;
            else if (state != S_IDLE && bus.i_abort)   abort_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_hit && !frame_empty) begin
                        remaining  <= bus.i_frame_len;
                        pkt_offset <= 24'd0;
                        pkt_rank   <= 15'd0;
                    end
                end
                S_LOAD: begin
                    pkt_len  <= fits ? remaining[15:0] : MAX_LEN[15:0];
                    pkt_last <= fits;
                end
                S_WAIT_DONE: begin
                    if (!bus.i_send_busy) begin
                        remaining  <= remaining - {8'd0, pkt_len};
                        pkt_offset <= pkt_offset + {8'd0, pkt_len};
                        ipv4_sign  <= ipv4_sign + 16'd1;
                        gap_cnt    <= '0;
                        // Rank only advances when another packet of this frame will follow.
                        if (!pkt_last && !abort_q) pkt_rank <= pkt_rank + 15'd1;
                    end
                end
                S_GAP:   gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.o_frame_ready   = (state == S_IDLE);
    assign bus.o_frame_done    = (state == S_DONE) || zero_done;
    assign bus.o_frame_aborted = (state == S_DONE) && abort_q;
    assign bus.o_send_en       = (state == S_ISSUE);
    assign bus.o_pkt_len       = pkt_len;
    assign bus.o_pkt_last      = pkt_last;
    assign bus.o_pkt_rank      = pkt_rank;
    assign bus.o_ipv4_sign     = ipv4_sign;
    assign bus.o_pkt_offset    = pkt_offset;
endmodule

// File: tb/tb_udp_jpeg_pkt_scheduler.sv
// tb/tb_udp_jpeg_pkt_scheduler.sv - scoreboard bench for udp_jpeg_pkt_scheduler
module tb_udp_jpeg_pkt_scheduler;
    localparam int          MAXP  = 1024;
    localparam int          GAP   = 16;
    localparam logic [15:0] SIGN0 = 16'hFFFE;

    typedef struct packed {
        logic [15:0] len;
        logic        last;
        logic [14:0] rank;
        logic [23:0] off;
        logic [15:0] sign;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    udp_jpeg_pkt_scheduler_if bus ();

    udp_jpeg_pkt_scheduler #(
        .MAX_PAYLOAD   (MAXP),
        .GAP_CYCLES    (GAP),
        .IPV4_SIGN_INIT(SIGN0)
    ) dut (
        .i_udp_clk50m(clk),
        .i_rst       (rst),
        .bus         (bus)
    );

    pkt_t        exp_q[$];
    int          send_cyc_q[$];
    int          fall_q[$];
    int          done_cyc_q[$];
    logic [15:0] sign_q[$];
    int          sends = 0;
    int          dones = 0;
    logic        last_aborted = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] model_sign = SIGN0;
    int          busy_len = 40;

    initial forever @(posedge clk) cyc++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Monitor: every start pulse pops the expected packet and compares all fields.
    initial begin
        pkt_t o;
        pkt_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (bus.o_send_en === 1'b1) begin
                    o = {bus.o_pkt_len, bus.o_pkt_last, bus.o_pkt_rank, bus.o_pkt_offset, bus.o_ipv4_sign};
                    sends++;
                    send_cyc_q.push_back(cyc);
                    sign_q.push_back(bus.o_ipv4_sign);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_send: got len=%0d rank=%0d off=%0d, required no packet",
                                 o.len, o.rank, o.off);
                    end else begin
                        e = exp_q.pop_front();
                        if (o !== e)
                            $display("FAIL pkt_fields: got len=%0d last=%0b rank=%0d off=%0d sign=%h, required len=%0d last=%0b rank=%0d off=%0d sign=%h",
                                     o.len, o.last, o.rank, o.off, o.sign, e.len, e.last, e.rank, e.off, e.sign);
                        else
                            n_pass++;
                    end
                end
                if (bus.o_frame_done === 1'b1) begin
                    dones++;
                    last_aborted = bus.o_frame_aborted;
                    done_cyc_q.push_back(cyc);
                end
            end
        end
    end

    // Sender model: busy rises right after the start pulse and holds busy_len cycles.
    initial begin
        bus.i_send_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && bus.o_send_en === 1'b1) begin
                @(posedge clk);
                #1 bus.i_send_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.i_send_busy = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    task automatic push_frame(input int len, input int max_pkts);
        int   rem;
        int   off;
        int   r;
        int   l;
        pkt_t p;
        rem = len;
        off = 0;
        r   = 0;
        while (rem > 0 && r < max_pkts) begin
            l      = (rem > MAXP) ? MAXP : rem;
            p.len  = 16'(l);
            p.last = (rem <= MAXP);
            p.rank = 15'(r);
            p.off  = 24'(off);
            p.sign = model_sign;
            exp_q.push_back(p);
            model_sign = model_sign + 16'd1;
            rem -= l;
            off += l;
            r++;
        end
    endtask

    task automatic pulse_start(input logic [23:0] len, output int scyc);
        @(posedge clk);
        #1;
        bus.i_frame_len   = len;
        bus.i_frame_start = 1'b1;
        scyc = cyc;
        @(posedge clk);
        #1 bus.i_frame_start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (dones >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sends(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (sends >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        send_cyc_q.delete();
        fall_q.delete();
        done_cyc_q.delete();
        sign_q.delete();
    endtask

    function automatic logic [81:0] out_vec();
        return {bus.o_frame_ready, bus.o_frame_done, bus.o_frame_aborted, bus.o_send_en,
                bus.o_pkt_len, bus.o_pkt_last, bus.o_pkt_rank, bus.o_ipv4_sign, bus.o_pkt_offset};
    endfunction

    task automatic test_reset();
        logic [81:0] want;
        want = {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 15'd0, SIGN0, 24'd0};
        rst = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_frame_len   = 24'd0;
        bus.i_abort       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_vec() !== want) $display("FAIL reset_outputs: got %h, required %h", out_vec(), want);
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_frame_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", bus.o_frame_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int s0, d0, sc;
        bit ok;
        clear_logs();
        s0 = sends;
        d0 = dones;
        push_frame(3000, 99);
        pulse_start(24'd3000, sc);
        wait_dones(d0 + 1, 2000, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_done: got no o_frame_done, required one within 2000 cycles");
        else n_pass++;
        n_checks++;
        if (sends - s0 != 3) $display("FAIL basic_pkt_count: got %0d, required 3", sends - s0);
        else n_pass++;
        n_checks++;
        if (last_aborted !== 1'b0) $display("FAIL basic_aborted: got %b, required 0", last_aborted);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL basic_missing_pkts: got %0d unsent, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (bus.o_pkt_offset !== 24'd3000) $display("FAIL basic_final_offset: got %0d, required 3000", bus.o_pkt_offset);
        else n_pass++;
        n_checks++;
        if (send_cyc_q.size() < 1 || send_cyc_q[0] - sc != 2)
            $display("FAIL start_latency: got %0d, required 2", (send_cyc_q.size() < 1) ? -1 : send_cyc_q[0] - sc);
        else n_pass++;
        n_checks++;
        if (send_cyc_q.size() < 2 || fall_q.size() < 1 || send_cyc_q[1] - fall_q[0] != GAP + 2)
            $display("FAIL gap_latency: got %0d, required %0d",
                     (send_cyc_q.size() < 2 || fall_q.size() < 1) ? -1 : send_cyc_q[1] - fall_q[0], GAP + 2);
        else n_pass++;
        n_checks++;
        if (sign_q.size() != 3 || sign_q[0] !== 16'hFFFE || sign_q[1] !== 16'hFFFF || sign_q[2] !== 16'h0000)
            $display("FAIL sign_sequence: got %0d signs first %h, required FFFE/FFFF/0000",
                     sign_q.size(), (sign_q.size() > 0) ? sign_q[0] : 16'hxxxx);
        else n_pass++;
    endtask

    task automatic test_sign_wrap();
        int d0, sc;
        bit ok;
        clear_logs();
        d0 = dones;
        push_frame(100, 99);
        pulse_start(24'd100, sc);
        wait_dones(d0 + 1, 1000, ok);
        n_checks++;
        if (!ok || sign_q.size() != 1 || sign_q[0] !== 16'h0001)
            $display("FAIL next_frame_sign: got %h (ok=%0b), required 0001",
                     (sign_q.size() > 0) ? sign_q[0] : 16'hxxxx, ok);
        else n_pass++;
    endtask

    task automatic test_exact();
        int s0, d0, sc;
        bit ok;
        s0 = sends;
        d0 = dones;
        push_frame(1024, 99);
        pulse_start(24'd1024, sc);
        wait_dones(d0 + 1, 1000, ok);
        n_checks++;
        if (!ok || sends - s0 != 1) $display("FAIL exact_1024: got %0d pkts (ok=%0b), required 1", sends - s0, ok);
        else n_pass++;
        s0 = sends;
        push_frame(1025, 99);
        pulse_start(24'd1025, sc);
        wait_dones(d0 + 2, 1000, ok);
        n_checks++;
        if (!ok || sends - s0 != 2) $display("FAIL len_1025: got %0d pkts (ok=%0b), required 2", sends - s0, ok);
        else n_pass++;
        n_checks++;
        if (bus.o_pkt_len !== 16'd1 || bus.o_pkt_last !== 1'b1 || bus.o_pkt_offset !== 24'd1025)
            $display("FAIL len_1025_tail: got len=%0d last=%b off=%0d, required len=1 last=1 off=1025",
                     bus.o_pkt_len, bus.o_pkt_last, bus.o_pkt_offset);
        else n_pass++;
    endtask

    task automatic test_zero();
        int s0, d0, sc;
        bit bad;
        clear_logs();
        s0 = sends;
        d0 = dones;
        bad = 1'b0;
        pulse_start(24'd0, sc);
        repeat (6) begin
            @(negedge clk);
            if (bus.o_frame_ready !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL zero_ready: got ready low, required 1 throughout");
        else n_pass++;
        n_checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != sc + 1)
            $display("FAIL zero_done_timing: got %0d pulses at %0d, required 1 at %0d",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, sc + 1);
        else n_pass++;
        n_checks++;
        if (sends != s0 || dones - d0 != 1 || last_aborted !== 1'b0)
            $display("FAIL zero_no_pkt: got sends=%0d dones=%0d aborted=%b, required 0/1/0",
                     sends - s0, dones - d0, last_aborted);
        else n_pass++;
    endtask

    task automatic test_abort();
        int s0, d0, sc;
        bit ok;
        s0 = sends;
        d0 = dones;
        push_frame(5000, 2);
        pulse_start(24'd5000, sc);
        wait_sends(s0 + 2, 1000, ok);
        repeat (5) @(posedge clk);
        #1 bus.i_abort = 1'b1;
        @(posedge clk);
        #1 bus.i_abort = 1'b0;
        wait_dones(d0 + 1, 1000, ok);
        repeat (60) @(posedge clk);
        n_checks++;
        if (!ok || sends - s0 != 2 || last_aborted !== 1'b1)
            $display("FAIL abort_frame: got pkts=%0d aborted=%b ok=%0b, required pkts=2 aborted=1",
                     sends - s0, last_aborted, ok);
        else n_pass++;
        n_checks++;
        if (bus.o_pkt_offset !== 24'd2048) $display("FAIL abort_offset: got %0d, required 2048", bus.o_pkt_offset);
        else n_pass++;
        // Abort pulsed while idle must not poison the next frame.
        @(posedge clk);
        #1 bus.i_abort = 1'b1;
        @(posedge clk);
        #1 bus.i_abort = 1'b0;
        s0 = sends;
        push_frame(100, 99);
        pulse_start(24'd100, sc);
        wait_dones(d0 + 2, 1000, ok);
        n_checks++;
        if (!ok || sends - s0 != 1 || last_aborted !== 1'b0)
            $display("FAIL idle_abort_ignored: got pkts=%0d aborted=%b ok=%0b, required pkts=1 aborted=0",
                     sends - s0, last_aborted, ok);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s0, d0, sc, sc2;
        bit ok;
        logic [81:0] want;
        want = {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 15'd0, SIGN0, 24'd0};
        s0 = sends;
        push_frame(3000, 1);
        pulse_start(24'd3000, sc);
        wait_sends(s0 + 1, 1000, ok);
        repeat (5) @(posedge clk);
        #5 rst = 1'b1;
        #1;
        n_checks++;
        if (out_vec() !== want) $display("FAIL async_reset_outputs: got %h, required %h", out_vec(), want);
        else n_pass++;
        exp_q.delete();
        model_sign = SIGN0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 200 && bus.i_send_busy !== 1'b0; i++) @(posedge clk);
        s0 = sends;
        d0 = dones;
        push_frame(2048, 99);
        pulse_start(24'd2048, sc);
        wait_sends(s0 + 1, 1000, ok);
        pulse_start(24'd2048, sc2);
        wait_dones(d0 + 1, 2000, ok);
        repeat (80) @(posedge clk);
        n_checks++;
        if (!ok || sends - s0 != 2 || dones - d0 != 1)
            $display("FAIL start_while_busy: got pkts=%0d dones=%0d ok=%0b, required pkts=2 dones=1",
                     sends - s0, dones - d0, ok);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_wrap();
        test_exact();
        test_zero();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
